// File: rtl/alu_pkg.sv
// Shared EX-stage definitions: ALU control codes and the mul/div sequencer encodings.
// Imported by ALU control, the ALU and the muldiv sequencer.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_DIV = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2,
    DONE    = 2'd3
  } muldiv_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } muldiv_mode_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative datapath: shift-add multiply step or restoring divide step per cycle.
// Holds the accumulator/remainder, the multiplier/quotient and the multiplicand/divisor.
module muldiv_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  muldiv_mode_e     mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // rem_sh never exceeds 2*divisor-1, so diff's MSB is exactly the borrow of rem - divisor.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, (lo[0] ? opnd : '0)};
    rem_sh = {acc, lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd};
    hi_nxt = '0;
    lo_nxt = '0;
    if (mode == MODE_MUL) begin
      hi_nxt = sum[WIDTH:1];
      lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_nxt = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      lo   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      opnd <= (mode == MODE_MUL) ? op_a : op_b;
      lo   <= (mode == MODE_MUL) ? op_b : op_a;
    end else if (step) begin
      acc <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MUL/DIV controller beside the EX-stage ALU; stalls the pipe while iterating.
// Optional MULDIV_SIGNED_EN: two's-complement operands with sign fix-up on entry to DONE.
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_e     state, state_nxt;
  logic [CNT_W-1:0]  counter, cnt_nxt;
  logic              dp_load, dp_step;
  muldiv_mode_e      dp_mode;
  logic [WIDTH-1:0]  dp_hi_nxt, dp_lo_nxt;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic              launch_mul, launch_div;
  logic              res_load, dz_nxt;
  logic [WIDTH-1:0]  res_lo_nxt, res_hi_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]  quo, rem;

`ifdef MULDIV_SIGNED_EN
  logic neg_q, neg_r;

  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (dp_load) begin
      neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_r <= op_a[WIDTH-1];
    end
  end
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
`endif

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .mode   (dp_mode),
    .op_a   (a_mag),
    .op_b   (b_mag),
    .hi_nxt (dp_hi_nxt),
    .lo_nxt (dp_lo_nxt)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = counter;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    dp_mode    = MODE_MUL;
    res_load   = 1'b0;
    res_lo_nxt = '0;
    res_hi_nxt = '0;
    dz_nxt     = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    launch_mul = start && (alu_ctrl == ALU_MUL);
    launch_div = start && (alu_ctrl == ALU_DIV);

    prod = {dp_hi_nxt, dp_lo_nxt};
    quo  = dp_lo_nxt;
    rem  = dp_hi_nxt;
`ifdef MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_r) rem = -rem;
`endif

    unique case (state)
      IDLE: begin
        if (launch_mul) begin
          stall     = 1'b1;
          dp_load   = 1'b1;
          state_nxt = MUL_RUN;
          cnt_nxt   = CNT_W'(WIDTH);
        end else if (launch_div) begin
          stall   = 1'b1;
          dp_mode = MODE_DIV;
          if (op_b == '0) begin
            state_nxt  = DONE;
            res_load   = 1'b1;
            res_lo_nxt = '1;
            res_hi_nxt = op_a;
            dz_nxt     = 1'b1;
          end else begin
            dp_load   = 1'b1;
            state_nxt = DIV_RUN;
            cnt_nxt   = CNT_W'(WIDTH);
          end
        end
      end
      MUL_RUN: begin
        stall   = 1'b1;
        dp_step = 1'b1;
        cnt_nxt = counter - CNT_W'(1);
        if (counter == CNT_W'(1)) begin
          state_nxt                = DONE;
          res_load                 = 1'b1;
          {res_hi_nxt, res_lo_nxt} = prod;
        end
      end
      DIV_RUN: begin
        stall   = 1'b1;
        dp_step = 1'b1;
        dp_mode = MODE_DIV;
        cnt_nxt = counter - CNT_W'(1);
        if (counter == CNT_W'(1)) begin
          state_nxt  = DONE;
          res_load   = 1'b1;
          res_lo_nxt = quo;
          res_hi_nxt = rem;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort wins over launch, stepping and completion; stall from a run state holds this cycle.
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      res_load  = 1'b0;
      done      = 1'b0;
      if (state == IDLE) stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
    end else begin
      state   <= state_nxt;
      counter <= cnt_nxt;
      if (res_load) begin
        result_lo <= res_lo_nxt;
        result_hi <= res_hi_nxt;
        div_zero  <= dz_nxt;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32); signed cases under MULDIV_SIGNED_EN.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   alu_ctrl = ALU_AND;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         stall, done, div_zero;
  logic [W-1:0] result_lo, result_hi;

  int tests = 0;
  int fails = 0;
  int stall0;
  int cyc, stalls, seen;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .stall     (stall),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start at a falling edge; returns in cycle 1 (just after the next falling edge).
  task automatic launch(input logic [2:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    #1 stall0 = int'(stall);
    @(negedge clk);
    start = 1'b0; alu_ctrl = ALU_AND;
  endtask

  // Sample each cycle from c0 on; cyc stays -1 if done never arrives within the budget.
  task automatic wait_done(input int c0, output int cyc_o, output int stalls_o);
    cyc_o = -1; stalls_o = 0;
    for (int c = c0; c <= 80; c++) begin
      #1;
      if (done) begin
        cyc_o = c;
        break;
      end
      stalls_o += int'(stall);
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_lo", result_lo, 0);
    check("rst_hi", result_hi, 0);
    check("rst_dz", div_zero, 0);
    rst = 1'b0;

    // MUL 7 x 6
    launch(ALU_MUL, 32'd7, 32'd6);
    check("mul7x6_stall0", stall0, 1);
    wait_done(1, cyc, stalls);
    check("mul7x6_done_cyc", cyc, 33);
    check("mul7x6_stall_cycles", stall0 + stalls, 33);
    check("mul7x6_stall_at_done", stall, 0);
    check("mul7x6_lo", result_lo, 42);
    check("mul7x6_hi", result_hi, 0);
    check("mul7x6_dz", div_zero, 0);
    @(negedge clk); #1;
    check("mul7x6_done_pulse", done, 0);
    check("mul7x6_hold_lo", result_lo, 42);

    // MUL all-ones squared
    launch(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc, stalls);
    check("mulmax_done_cyc", cyc, 33);
`ifdef MULDIV_SIGNED_EN
    check("mulmax_hi", result_hi, 32'h0000_0000);
`else
    check("mulmax_hi", result_hi, 32'hFFFF_FFFE);
`endif
    check("mulmax_lo", result_lo, 32'h0000_0001);

    // DIV 100 / 7
    launch(ALU_DIV, 32'd100, 32'd7);
    wait_done(1, cyc, stalls);
    check("div100_done_cyc", cyc, 33);
    check("div100_lo", result_lo, 14);
    check("div100_hi", result_hi, 2);
    check("div100_dz", div_zero, 0);

    // DIV 5 / 0
    launch(ALU_DIV, 32'd5, 32'd0);
    check("div0_stall0", stall0, 1);
    wait_done(1, cyc, stalls);
    check("div0_done_cyc", cyc, 1);
    check("div0_lo", result_lo, 32'hFFFF_FFFF);
    check("div0_hi", result_hi, 5);
    check("div0_dz", div_zero, 1);

    // ADD is not ours: no stall, no done
    @(negedge clk);
    start = 1'b1; alu_ctrl = ALU_ADD; op_a = 32'd3; op_b = 32'd4;
    #1 check("add_stall", stall, 0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      seen += int'(done) + int'(stall);
    end
    start = 1'b0; alu_ctrl = ALU_AND;
    check("add_no_done_no_stall", seen, 0);
    check("add_hold_lo", result_lo, 32'hFFFF_FFFF);

    // DIV 1000 / 9 with a MUL start at cycle 10 that must be ignored
    launch(ALU_DIV, 32'd1000, 32'd9);
    repeat (9) @(negedge clk);
    start = 1'b1; alu_ctrl = ALU_MUL; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; alu_ctrl = ALU_AND;
    wait_done(11, cyc, stalls);
    check("divign_done_cyc", cyc, 33);
    check("divign_lo", result_lo, 111);
    check("divign_hi", result_hi, 1);
    @(negedge clk); #1;
    check("divign_idle_after", stall, 0);

    // flush at cycle 15 of a MUL
    launch(ALU_MUL, 32'd7, 32'd6);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_stall_same_cycle", stall, 1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_stall_next", stall, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      seen += int'(done);
      @(negedge clk); #1;
    end
    check("flush_no_done", seen, 0);
    check("flush_hold_lo", result_lo, 111);
    check("flush_hold_hi", result_hi, 1);
    launch(ALU_DIV, 32'd100, 32'd7);
    wait_done(1, cyc, stalls);
    check("postflush_done_cyc", cyc, 33);
    check("postflush_lo", result_lo, 14);
    check("postflush_hi", result_hi, 2);

    // rst at cycle 20 of a DIV
    launch(ALU_DIV, 32'd5000, 32'd3);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("midrst_stall", stall, 0);
    check("midrst_done", done, 0);
    check("midrst_lo", result_lo, 0);
    check("midrst_hi", result_hi, 0);
    check("midrst_dz", div_zero, 0);
    rst = 1'b0;
    launch(ALU_MUL, 32'd12, 32'd11);
    wait_done(1, cyc, stalls);
    check("postrst_done_cyc", cyc, 33);
    check("postrst_lo", result_lo, 132);
    check("postrst_hi", result_hi, 0);

`ifdef MULDIV_SIGNED_EN
    launch(ALU_MUL, -32'sd7, 32'sd6);
    wait_done(1, cyc, stalls);
    check("smul_done_cyc", cyc, 33);
    check("smul_lo", result_lo, 32'hFFFF_FFD6);
    check("smul_hi", result_hi, 32'hFFFF_FFFF);

    launch(ALU_DIV, -32'sd100, 32'sd7);
    wait_done(1, cyc, stalls);
    check("sdiv_lo", result_lo, 32'hFFFF_FFF2);
    check("sdiv_hi", result_hi, 32'hFFFF_FFFE);

    launch(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, cyc, stalls);
    check("sdiv_ovf_lo", result_lo, 32'h8000_0000);
    check("sdiv_ovf_hi", result_hi, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
